// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for a five-stage pipeline: load-use stall, taken-branch flush,
// and HALT drain/stop sequencing, with saturating stall and flush statistics.
module pipe_hazard_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_valid,
    input  logic [31:0] id_inst,
    input  logic        ex_valid,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rd,
    input  logic        ex_branch_taken,
    output logic        stall_if,
    output logic        stall_id,
    output logic        bubble_ex,
    output logic        flush_if,
    output logic        halted,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    localparam logic [5:0] OP_STW  = 6'b001101;
    localparam logic [5:0] OP_BEQ  = 6'b001111;
    localparam logic [5:0] OP_HALT = 6'b010001;

    function automatic logic rs_used(input logic [5:0] op);
        return (op <= 6'b010000);
    endfunction

    function automatic logic rt_used(input logic [5:0] op);
        return ((op <= 6'b001010) && (op[0] == 1'b0)) || (op == OP_STW) || (op == OP_BEQ);
    endfunction

    state_t      state_r, state_nxt_s;
    logic [1:0]  drain_r, drain_nxt_s;
    logic [15:0] stall_cnt_r, flush_cnt_r;

    logic [5:0]  op_s;
    logic [4:0]  rs_s, rt_s;
    logic        lu_s, halt_dec_s, lu_stall_s;
    logic        stall_if_s, stall_id_s, bubble_ex_s, flush_if_s, halted_s;
    logic        unused_inst_s;

    assign op_s          = id_inst[31:26];
    assign rs_s          = id_inst[25:21];
    assign rt_s          = id_inst[20:16];
    assign unused_inst_s = ^id_inst[15:0];

    // ex_rd of zero never hazards, which also covers register-0 sources
    assign lu_s = id_valid && ex_valid && ex_mem_read && (ex_rd != 5'd0) &&
                  ((rs_used(op_s) && (rs_s == ex_rd)) || (rt_used(op_s) && (rt_s == ex_rd)));
    assign halt_dec_s = id_valid && (op_s == OP_HALT);

    // Next-state and per-cycle control decode; branch outranks load-use and HALT
    always_comb begin
        state_nxt_s = state_r;
        drain_nxt_s = drain_r;
        stall_if_s  = 1'b0;
        stall_id_s  = 1'b0;
        bubble_ex_s = 1'b0;
        flush_if_s  = 1'b0;
        halted_s    = 1'b0;
        lu_stall_s  = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (ex_branch_taken) begin
                    flush_if_s  = 1'b1;
                    bubble_ex_s = 1'b1;
                end else if (lu_s) begin
                    stall_if_s  = 1'b1;
                    stall_id_s  = 1'b1;
                    bubble_ex_s = 1'b1;
                    lu_stall_s  = 1'b1;
                end else if (halt_dec_s) begin
                    stall_if_s  = 1'b1;
                    drain_nxt_s = 2'd3;
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (ex_branch_taken) begin
                    flush_if_s  = 1'b1;
                    bubble_ex_s = 1'b1;
                    drain_nxt_s = 2'd0;
                    state_nxt_s = ST_RUN;
                end else begin
                    stall_if_s  = 1'b1;
                    stall_id_s  = 1'b1;
                    bubble_ex_s = 1'b1;
                    drain_nxt_s = drain_r - 2'd1;
                    if (drain_r == 2'd1) begin
                        state_nxt_s = ST_HALTED;
                    end else begin
                        state_nxt_s = ST_DRAIN;
                    end
                end
            end
            ST_HALTED: begin
                stall_if_s  = 1'b1;
                stall_id_s  = 1'b1;
                bubble_ex_s = 1'b1;
                halted_s    = 1'b1;
            end
            default: begin
                state_nxt_s = ST_RUN;
                drain_nxt_s = 2'd0;
            end
        endcase
    end

    // FSM state and drain counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_RUN;
            drain_r <= 2'd0;
        end else begin
            state_r <= state_nxt_s;
            drain_r <= drain_nxt_s;
        end
    end

    // Saturating statistics counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_r <= 16'd0;
            flush_cnt_r <= 16'd0;
        end else begin
            if (lu_stall_s && (stall_cnt_r != 16'hFFFF)) begin
                stall_cnt_r <= stall_cnt_r + 16'd1;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (flush_if_s && (flush_cnt_r != 16'hFFFF)) begin
                flush_cnt_r <= flush_cnt_r + 16'd1;
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

    // Controls are forced quiet while reset is held
    assign stall_if  = reset & stall_if_s;
    assign stall_id  = reset & stall_id_s;
    assign bubble_ex = reset & bubble_ex_s;
    assign flush_if  = reset & flush_if_s;
    assign halted    = reset & halted_s;
    assign stall_cnt = stall_cnt_r;
    assign flush_cnt = flush_cnt_r;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl: outputs are sampled 1 ns
// after inputs change (mid-cycle), counters 1 ns after the rising edge.
module tb_pipe_hazard_ctrl;

    logic        clk;
    logic        reset;
    logic        id_valid;
    logic [31:0] id_inst;
    logic        ex_valid;
    logic        ex_mem_read;
    logic [4:0]  ex_rd;
    logic        ex_branch_taken;
    logic        stall_if, stall_id, bubble_ex, flush_if, halted;
    logic [15:0] stall_cnt, flush_cnt;

    int pass_cnt  = 0;
    int total_cnt = 0;

    pipe_hazard_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .id_valid        (id_valid),
        .id_inst         (id_inst),
        .ex_valid        (ex_valid),
        .ex_mem_read     (ex_mem_read),
        .ex_rd           (ex_rd),
        .ex_branch_taken (ex_branch_taken),
        .stall_if        (stall_if),
        .stall_id        (stall_id),
        .bubble_ex       (bubble_ex),
        .flush_if        (flush_if),
        .halted          (halted),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {stall_if, stall_id, bubble_ex, flush_if, halted}
    logic [4:0] outs;
    assign outs = {stall_if, stall_id, bubble_ex, flush_if, halted};

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt);
        return {op, rs, rt, 16'h1234};
    endfunction

    task automatic drive(input logic idv, input logic [31:0] inst, input logic exv,
                         input logic mr, input logic [4:0] rd, input logic br);
        id_valid = idv; id_inst = inst; ex_valid = exv;
        ex_mem_read = mr; ex_rd = rd; ex_branch_taken = br;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        idle();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(1'b1, mk(6'b000000, 5'd5, 5'd0), 1'b1, 1'b1, 5'd5, 1'b1);
        total_cnt++;
        if (outs !== 5'b00000) $display("FAIL reset_outs: got %b want 00000", outs); else pass_cnt++;
        tick();
        total_cnt++;
        if ({stall_cnt, flush_cnt} !== 32'd0) $display("FAIL reset_cnts: got %h/%h want 0/0", stall_cnt, flush_cnt); else pass_cnt++;
        reset = 1'b1;
        idle();
        total_cnt++;
        if (outs !== 5'b00000) $display("FAIL reset_idle: got %b want 00000", outs); else pass_cnt++;
    endtask

    task automatic test_load_use();
        drive(1'b1, mk(6'b000000, 5'd5, 5'd2), 1'b1, 1'b1, 5'd5, 1'b0);
        total_cnt++;
        if (outs !== 5'b11100) $display("FAIL lu_rs: got %b want 11100", outs); else pass_cnt++;
        tick();
        total_cnt++;
        if (stall_cnt !== 16'd1) $display("FAIL lu_cnt1: got %0d want 1", stall_cnt); else pass_cnt++;
        drive(1'b1, mk(6'b000000, 5'd5, 5'd2), 1'b1, 1'b0, 5'd0, 1'b0);
        total_cnt++;
        if (outs !== 5'b00000) $display("FAIL lu_after: got %b want 00000", outs); else pass_cnt++;
        tick();
        drive(1'b1, mk(6'b001101, 5'd1, 5'd9), 1'b1, 1'b1, 5'd9, 1'b0);
        total_cnt++;
        if (outs !== 5'b11100) $display("FAIL lu_stw_rt: got %b want 11100", outs); else pass_cnt++;
        tick();
        drive(1'b1, mk(6'b001111, 5'd1, 5'd3), 1'b1, 1'b1, 5'd3, 1'b0);
        total_cnt++;
        if (outs !== 5'b11100) $display("FAIL lu_beq_rt: got %b want 11100", outs); else pass_cnt++;
        tick();
        total_cnt++;
        if (stall_cnt !== 16'd3) $display("FAIL lu_cnt3: got %0d want 3", stall_cnt); else pass_cnt++;
    endtask

    task automatic test_no_false_hazard();
        drive(1'b1, mk(6'b000000, 5'd0, 5'd0), 1'b1, 1'b1, 5'd0, 1'b0);
        total_cnt++;
        if (outs !== 5'b00000) $display("FAIL nf_r0: got %b want 00000", outs); else pass_cnt++;
        tick();
        drive(1'b1, mk(6'b000001, 5'd1, 5'd7), 1'b1, 1'b1, 5'd7, 1'b0);
        total_cnt++;
        if (outs !== 5'b00000) $display("FAIL nf_addi_rt: got %b want 00000", outs); else pass_cnt++;
        tick();
        drive(1'b1, mk(6'b111111, 5'd4, 5'd4), 1'b1, 1'b1, 5'd4, 1'b0);
        total_cnt++;
        if (outs !== 5'b00000) $display("FAIL nf_undef: got %b want 00000", outs); else pass_cnt++;
        tick();
        drive(1'b1, mk(6'b000000, 5'd6, 5'd2), 1'b0, 1'b1, 5'd6, 1'b0);
        total_cnt++;
        if (outs !== 5'b00000) $display("FAIL nf_exinv: got %b want 00000", outs); else pass_cnt++;
        tick();
        idle();
        total_cnt++;
        if (stall_cnt !== 16'd3) $display("FAIL nf_cnt: got %0d want 3", stall_cnt); else pass_cnt++;
    endtask

    task automatic test_branch_priority();
        drive(1'b1, mk(6'b000000, 5'd5, 5'd2), 1'b1, 1'b1, 5'd5, 1'b1);
        total_cnt++;
        if (outs !== 5'b00110) $display("FAIL br_lu: got %b want 00110", outs); else pass_cnt++;
        tick();
        total_cnt++;
        if ({stall_cnt, flush_cnt} !== {16'd3, 16'd1}) $display("FAIL br_cnts: got %0d/%0d want 3/1", stall_cnt, flush_cnt); else pass_cnt++;
        drive(1'b1, mk(6'b010001, 5'd0, 5'd0), 1'b0, 1'b0, 5'd0, 1'b1);
        total_cnt++;
        if (outs !== 5'b00110) $display("FAIL br_halt: got %b want 00110", outs); else pass_cnt++;
        tick();
        idle();
        total_cnt++;
        if (outs !== 5'b00000) $display("FAIL br_halt_run: got %b want 00000", outs); else pass_cnt++;
    endtask

    task automatic test_halt();
        drive(1'b1, mk(6'b010001, 5'd0, 5'd0), 1'b0, 1'b0, 5'd0, 1'b0);
        total_cnt++;
        if (outs !== 5'b10000) $display("FAIL halt_dec: got %b want 10000", outs); else pass_cnt++;
        tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            total_cnt++;
            if (outs !== 5'b11100) $display("FAIL halt_drain%0d: got %b want 11100", i, outs); else pass_cnt++;
            tick();
        end
        for (int i = 0; i < 12; i++) begin
            drive(1'($urandom), $urandom, 1'($urandom), 1'($urandom), 5'($urandom), 1'($urandom));
            total_cnt++;
            if (outs !== 5'b11101) $display("FAIL halted%0d: got %b want 11101", i, outs); else pass_cnt++;
            tick();
        end
        total_cnt++;
        if ({stall_cnt, flush_cnt} !== {16'd3, 16'd2}) $display("FAIL halt_cnts: got %0d/%0d want 3/2", stall_cnt, flush_cnt); else pass_cnt++;
    endtask

    task automatic test_reset_mid_halted();
        do_reset();
        total_cnt++;
        if (outs !== 5'b00000) $display("FAIL rst_halted_outs: got %b want 00000", outs); else pass_cnt++;
        total_cnt++;
        if ({stall_cnt, flush_cnt} !== 32'd0) $display("FAIL rst_halted_cnts: got %h/%h want 0/0", stall_cnt, flush_cnt); else pass_cnt++;
        tick();
        total_cnt++;
        if (outs !== 5'b00000) $display("FAIL rst_halted_next: got %b want 00000", outs); else pass_cnt++;
    endtask

    task automatic test_wrong_path_halt();
        drive(1'b1, mk(6'b010001, 5'd0, 5'd0), 1'b0, 1'b0, 5'd0, 1'b0);
        tick();
        idle();
        total_cnt++;
        if (outs !== 5'b11100) $display("FAIL wp_drain1: got %b want 11100", outs); else pass_cnt++;
        tick();
        drive(1'b0, 32'd0, 1'b1, 1'b0, 5'd0, 1'b1);
        total_cnt++;
        if ({flush_if, bubble_ex, halted} !== 3'b110) $display("FAIL wp_flush: got %b want 110", {flush_if, bubble_ex, halted}); else pass_cnt++;
        tick();
        idle();
        for (int i = 0; i < 4; i++) begin
            total_cnt++;
            if (outs !== 5'b00000) $display("FAIL wp_run%0d: got %b want 00000", i, outs); else pass_cnt++;
            tick();
        end
        total_cnt++;
        if (flush_cnt !== 16'd1) $display("FAIL wp_fcnt: got %0d want 1", flush_cnt); else pass_cnt++;
    endtask

    task automatic test_saturation();
        do_reset();
        drive(1'b1, mk(6'b000010, 5'd1, 5'd8), 1'b1, 1'b1, 5'd8, 1'b0);
        for (int i = 0; i < 65535; i++) tick();
        total_cnt++;
        if (stall_cnt !== 16'hFFFF) $display("FAIL sat_reach: got %h want ffff", stall_cnt); else pass_cnt++;
        total_cnt++;
        if (outs !== 5'b11100) $display("FAIL sat_outs: got %b want 11100", outs); else pass_cnt++;
        tick();
        total_cnt++;
        if (stall_cnt !== 16'hFFFF) $display("FAIL sat_hold: got %h want ffff", stall_cnt); else pass_cnt++;
        idle();
        total_cnt++;
        if (outs !== 5'b00000) $display("FAIL sat_idle: got %b want 00000", outs); else pass_cnt++;
    endtask

    initial begin
        reset = 1'b0;
        id_valid = 1'b0; id_inst = 32'd0; ex_valid = 1'b0;
        ex_mem_read = 1'b0; ex_rd = 5'd0; ex_branch_taken = 1'b0;
        #2;
        test_reset();
        test_load_use();
        test_no_false_hazard();
        test_branch_priority();
        test_halt();
        test_reset_mid_halted();
        test_wrong_path_halt();
        test_saturation();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
